// File: rtl/m_uart_hex_tx_if.sv
// ----------------------------------------------------------------------------
// m_uart_hex_tx_if : word handshake and transmitter VALID/DIN/BUSY bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface m_uart_hex_tx_if #(
  parameter int NIBBLES = 8
);
  logic                   VALID;
  logic [4*NIBBLES-1:0]   DIN;
  logic                   READY;
  logic                   TX_VALID;
  logic [7:0]             TX_DATA;
  logic                   TX_BUSY;

  // master = word source plus byte transmitter; slave = the hex renderer
  modport master (
    output VALID, DIN, TX_BUSY,
    input  READY, TX_VALID, TX_DATA
  );

  modport slave (
    input  VALID, DIN, TX_BUSY,
    output READY, TX_VALID, TX_DATA
  );
endinterface

`default_nettype wire

// File: rtl/m_uart_hex_tx.sv
// ----------------------------------------------------------------------------
// m_uart_hex_tx : renders a word as uppercase ASCII hex (+ optional CR LF)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module m_uart_hex_tx #(
  parameter int NIBBLES = 8,
  parameter int NEWLINE = 1
) (
  input  wire logic        CLK,
  input  wire logic        RST,
  m_uart_hex_tx_if.slave   bus
);

  localparam int c_LEN = NIBBLES + 2 * NEWLINE;
  localparam int c_CW  = $clog2(c_LEN + 1);
  localparam int c_DW  = 4 * NIBBLES;

  localparam logic [c_CW-1:0] c_LEN_V = c_CW'(c_LEN);
  localparam logic [c_CW-1:0] c_NIB_V = c_CW'(NIBBLES);
  localparam logic [c_CW-1:0] c_ONE   = c_CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_SEND = 2'd2
  } t_state;

  t_state            r_state;
  logic [c_CW-1:0]   r_cnt;
  logic [c_DW-1:0]   r_shift;
  logic              r_ready;
  logic              r_tx_valid;
  logic [7:0]        r_tx_data;
  logic [7:0]        w_char;

  function automatic logic [7:0] f_hex(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Digits come from the top nibble of the shift register; CR then LF follow.
  always_comb begin
    w_char = 8'h0A;
    if (r_cnt < c_NIB_V) begin
      w_char = f_hex(r_shift[c_DW-1 -: 4]);
    end else if (r_cnt == c_NIB_V) begin
      w_char = 8'h0D;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_ready    <= 1'b1;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_tx_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.VALID) begin
            r_shift <= bus.DIN;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!bus.TX_BUSY) begin
            if (r_cnt < c_LEN_V) begin
              r_tx_data  <= w_char;
              r_tx_valid <= 1'b1;
              r_state    <= S_SEND;
            end else begin
              r_ready <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        S_SEND: begin
          r_cnt <= r_cnt + c_ONE;
          if (r_cnt < c_NIB_V) begin
            r_shift <= r_shift << 4;
          end
          r_state <= S_WAIT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.READY    = r_ready;
  assign bus.TX_VALID = r_tx_valid;
  assign bus.TX_DATA  = r_tx_data;

endmodule

`default_nettype wire

// File: tb/tb_m_uart_hex_tx.sv
// ----------------------------------------------------------------------------
// tb_m_uart_hex_tx : directed checks for 8-digit+CRLF and 2-digit variants
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_m_uart_hex_tx;

  logic clk = 1'b0;
  logic rst;
  logic ext_busy;
  int   cyc = 0;
  int   a_bcnt = 0;
  int   b_bcnt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct {
    logic [7:0] d;
    int         c;
    logic       r;
  } t_ev;

  t_ev qa[$];
  t_ev qb[$];

  always #5 clk = ~clk;

  m_uart_hex_tx_if #(.NIBBLES(8)) a_if ();
  m_uart_hex_tx_if #(.NIBBLES(2)) b_if ();

  m_uart_hex_tx #(.NIBBLES(8), .NEWLINE(1)) u_a (.CLK(clk), .RST(rst), .bus(a_if.slave));
  m_uart_hex_tx #(.NIBBLES(2), .NEWLINE(0)) u_b (.CLK(clk), .RST(rst), .bus(b_if.slave));

  // Transmitter model, WAIT_DIV = 4: BUSY registered, high 40 cycles per strobe
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_if.TX_VALID) a_bcnt <= 40;
    else if (a_bcnt != 0) a_bcnt <= a_bcnt - 1;
    if (b_if.TX_VALID) b_bcnt <= 40;
    else if (b_bcnt != 0) b_bcnt <= b_bcnt - 1;
  end

  assign a_if.TX_BUSY = (a_bcnt != 0) || ext_busy;
  assign b_if.TX_BUSY = (b_bcnt != 0);

  always @(negedge clk) begin
    if (a_if.TX_VALID) qa.push_back('{d: a_if.TX_DATA, c: cyc, r: a_if.READY});
    if (b_if.TX_VALID) qb.push_back('{d: b_if.TX_DATA, c: cyc, r: b_if.READY});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // acc = cycle in which VALID && READY is seen (the accept edge ends it)
  task automatic send(input bit sel, input logic [31:0] w, input bit hold, output int acc);
    int n = 0;
    @(negedge clk);
    if (sel) begin b_if.VALID = 1'b1; b_if.DIN = w[7:0]; end
    else     begin a_if.VALID = 1'b1; a_if.DIN = w; end
    while (!(sel ? b_if.READY : a_if.READY) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("send_timeout", 0, 1);
    acc = cyc;
    @(posedge clk);
    #1;
    if (!hold) begin a_if.VALID = 1'b0; b_if.VALID = 1'b0; end
  endtask

  task automatic wait_ready(input bit sel, output int rc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sel ? b_if.READY : a_if.READY) && n < 3000);
    if (n >= 3000) chk("ready_timeout", 0, 1);
    rc = cyc;
  endtask

  task automatic wait_strobes(input int cnt);
    int n = 0;
    while (qa.size() < cnt && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 3000) chk("strobe_timeout", 0, 1);
  endtask

  task automatic chk_frame(input string tag, input int base, input logic [79:0] ef);
    chk({tag, "_count_ge"}, (qa.size() >= base + 10), 1);
    if (qa.size() < base + 10) return;
    for (int i = 0; i < 10; i++) begin
      chk({tag, "_byte"}, qa[base+i].d, ef[8*(9-i) +: 8]);
      chk({tag, "_ready_low"}, qa[base+i].r, 0);
    end
    for (int i = 1; i < 10; i++) chk({tag, "_spacing"}, qa[base+i].c - qa[base+i-1].c, 42);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, rc, f;
    rst = 1'b1; ext_busy = 1'b0;
    a_if.VALID = 1'b0; a_if.DIN = '0;
    b_if.VALID = 1'b0; b_if.DIN = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", a_if.READY, 1);
    chk("rst_tx_valid", a_if.TX_VALID, 0);
    chk("rst_tx_data", a_if.TX_DATA, 8'h00);
    chk("rst_ready_b", b_if.READY, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic frame 0123ABCD
    qa.delete();
    send(0, 32'h0123ABCD, 0, acc);
    wait_ready(0, rc);
    #1;
    chk("f1_count", qa.size(), 10);
    chk_frame("f1", 0, {8'h30, 8'h31, 8'h32, 8'h33, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A});
    if (qa.size() == 10) begin
      chk("f1_first_latency", qa[0].c - acc, 2);
      chk("f1_ready_rise", rc - qa[9].c, 42);
    end

    // Back-to-back FFFFFFFF then 00000000 with VALID held
    qa.delete();
    send(0, 32'hFFFFFFFF, 1, acc);
    a_if.DIN = 32'h00000000;
    wait_ready(0, rc);
    @(posedge clk);
    #1 a_if.VALID = 1'b0;
    wait_ready(0, rc);
    #1;
    chk("b2b_count", qa.size(), 20);
    chk_frame("b2b_ff", 0, {{8{8'h46}}, 8'h0D, 8'h0A});
    chk_frame("b2b_00", 10, {{8{8'h30}}, 8'h0D, 8'h0A});
    if (qa.size() == 20) chk("b2b_gap", qa[10].c - qa[9].c, 44);

    // VALID pulse while busy must be ignored
    qa.delete();
    send(0, 32'h0123ABCD, 0, acc);
    wait_strobes(3);
    @(negedge clk);
    a_if.VALID = 1'b1; a_if.DIN = 32'h00000011;
    @(negedge clk);
    a_if.VALID = 1'b0;
    wait_ready(0, rc);
    repeat (60) @(negedge clk);
    #1;
    chk("ign_count", qa.size(), 10);
    chk_frame("ign", 0, {8'h30, 8'h31, 8'h32, 8'h33, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A});

    // Reset after third strobe drops the remainder
    qa.delete();
    send(0, 32'h0123ABCD, 0, acc);
    wait_strobes(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", a_if.READY, 1);
    chk("mid_rst_tx_valid", a_if.TX_VALID, 0);
    chk("mid_rst_tx_data", a_if.TX_DATA, 8'h00);
    repeat (100) @(negedge clk);
    #1;
    chk("mid_rst_dropped", qa.size(), 3);
    send(0, 32'h89ABCDEF, 0, acc);
    wait_ready(0, rc);
    #1;
    chk("post_rst_count", qa.size(), 13);
    chk_frame("post_rst", 3, {8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h0D, 8'h0A});

    // External BUSY held at accept
    qa.delete();
    @(negedge clk);
    ext_busy = 1'b1;
    send(0, 32'hCAFE0001, 0, acc);
    repeat (50) @(negedge clk);
    chk("xbusy_none_yet", qa.size(), 0);
    ext_busy = 1'b0;
    f = cyc;
    wait_ready(0, rc);
    #1;
    chk("xbusy_count", qa.size(), 10);
    chk_frame("xbusy", 0, {8'h43, 8'h41, 8'h46, 8'h45, 8'h30, 8'h30, 8'h30, 8'h31, 8'h0D, 8'h0A});
    if (qa.size() == 10) chk("xbusy_first", qa[0].c - f, 1);

    // Two digits, no newline
    qb.delete();
    send(1, 32'h0000005A, 0, acc);
    wait_ready(1, rc);
    #1;
    chk("n2_count", qb.size(), 2);
    if (qb.size() == 2) begin
      chk("n2_byte0", qb[0].d, 8'h35);
      chk("n2_byte1", qb[1].d, 8'h41);
      chk("n2_first_latency", qb[0].c - acc, 2);
      chk("n2_spacing", qb[1].c - qb[0].c, 42);
      chk("n2_ready_rise", rc - qb[1].c, 42);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
